// File: rtl/led_pkg.sv
// Shared constants for the LED scanner: mode encodings, direction values and
// small helpers that name the mode bits.
package led_pkg;

  localparam logic [1:0] MODE_DOT_WRAP   = 2'b00;
  localparam logic [1:0] MODE_DOT_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_BAR_WRAP   = 2'b10;
  localparam logic [1:0] MODE_BAR_BOUNCE = 2'b11;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic mode_is_bounce(input logic [1:0] m);
    return m[0];
  endfunction

  function automatic logic mode_is_bar(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Step prescaler: counts enabled cycles and fires a step on the cycle where
// the count has reached the divisor, so steps come every div+1 enabled cycles.
module tick_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // '>=' rather than '==' so that shrinking div below the running count
  // fires on the next enabled cycle instead of waiting for a wrap.
  always_comb begin
    step    = 1'b0;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q >= div) begin
        step    = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// LED position scanner: moves a dot or bar across WIDTH LEDs in wrap or
// ping-pong order, stepping on a programmable prescaler.
module led_scanner
  import led_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DIV_W = 8,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             increase,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
  output logic [WIDTH-1:0] out,
  output logic [POS_W-1:0] position,
  output logic             tick,
  output logic             at_end
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic [1:0]       mode_q;
  logic             mode_change;
  logic             step;

  assign mode_change = (mode != mode_q);

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (mode_change),
    .div    (step_div),
    .step   (step)
  );

  // tick is a one-cycle strobe with no back-pressure: it is high exactly in
  // the cycle where a freshly stepped position is first on 'position'/'out'.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (mode_change) begin
      // A mode switch swallows any due step; bounce entry seeds direction.
      if (mode_is_bounce(mode)) begin
        dir_d = increase;
      end
    end else if (step) begin
      tick_d = 1'b1;
      if (!mode_is_bounce(mode_q)) begin
        dir_d = increase;
        if (increase == DIR_UP) begin
          pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
        end else begin
          pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
        end
      end else if (dir_q == DIR_UP) begin
        if (pos_q == POS_MAX) begin
          pos_d = POS_MAX - POS_W'(1);
          dir_d = DIR_DOWN;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d = POS_W'(1);
          dir_d = DIR_UP;
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      mode_q <= MODE_DOT_WRAP;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      mode_q <= mode;
    end
  end

  // Pattern decode follows the registered mode so out never glitches on a
  // mode input that has not yet been accepted.
  always_comb begin
    out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_is_bar(mode_q)) begin
        out[i] = (i <= int'(pos_q));
      end else begin
        out[i] = (i == int'(pos_q));
      end
    end
  end

  assign position = pos_q;
  assign tick     = tick_q;
  assign at_end   = (pos_q == '0) || (pos_q == POS_MAX);

  a_pos_in_range: assert property (@(posedge clk) disable iff (rst) pos_q <= POS_MAX);
  a_out_nonzero:  assert property (@(posedge clk) disable iff (rst) out != '0);

endmodule

// File: tb/tb_led_scanner.sv
// Randomised scoreboard bench for led_scanner: a 16-LED and a 10-LED instance
// share stimulus and are checked against a behavioural position model.
module tb_led_scanner;
  import led_pkg::*;

  localparam int W0    = 16;
  localparam int W1    = 10;
  localparam int DW    = 8;
  localparam int EXP_W = 104;

  // ---------------- clock / reset / DUTs ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          increase;
  logic [1:0]    mode;
  logic [DW-1:0] step_div;

  logic [W0-1:0] out0;
  logic [3:0]    pos0;
  logic          tick0, at_end0;
  logic [W1-1:0] out1;
  logic [3:0]    pos1;
  logic          tick1, at_end1;

  always #5 clk = ~clk;

  led_scanner #(.WIDTH(W0), .DIV_W(DW)) u_dut16 (
    .clk(clk), .rst(rst), .enable(enable), .increase(increase), .mode(mode),
    .step_div(step_div), .out(out0), .position(pos0), .tick(tick0), .at_end(at_end0)
  );

  led_scanner #(.WIDTH(W1), .DIV_W(DW)) u_dut10 (
    .clk(clk), .rst(rst), .enable(enable), .increase(increase), .mode(mode),
    .step_div(step_div), .out(out1), .position(pos1), .tick(tick1), .at_end(at_end1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // entry = {cycle the tick is expected, position, LED pattern}
  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_since;
  logic [1:0] m_mode;
  int         m_pos[2];
  int         m_dir[2];

  function automatic int lane_width(input int lane);
    return (lane == 0) ? W0 : W1;
  endfunction

  function automatic logic [63:0] pattern(input int p, input logic bar);
    if (bar) return (64'd1 << (p + 1)) - 64'd1;
    return 64'd1 << p;
  endfunction

  task automatic model_reset();
    m_since = 0;
    m_mode  = MODE_DOT_WRAP;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0;
      m_dir[i] = 1;
    end
  endtask

  task automatic model_advance(input int lane);
    int w, nxt;
    w = lane_width(lane);
    if (!m_mode[0]) begin
      m_pos[lane] = (m_pos[lane] + (increase ? 1 : -1) + w) % w;
    end else begin
      nxt = m_pos[lane] + m_dir[lane];
      if (nxt < 0 || nxt >= w) begin
        m_dir[lane] = -m_dir[lane];
        nxt = m_pos[lane] + m_dir[lane];
      end
      m_pos[lane] = nxt;
    end
  endtask

  // Predicts what the coming rising edge does with the inputs now applied.
  task automatic model_edge();
    logic [EXP_W-1:0] e;
    if (mode !== m_mode) begin
      m_mode  = mode;
      m_since = 0;
      if (mode[0]) begin
        for (int i = 0; i < 2; i++) m_dir[i] = increase ? 1 : -1;
      end
    end else if (enable) begin
      if (m_since >= int'(step_div)) begin
        m_since = 0;
        for (int i = 0; i < 2; i++) begin
          model_advance(i);
          e = {32'(cyc + 1), 8'(m_pos[i]), pattern(m_pos[i], m_mode[1])};
          if (i == 0) exp_q0.push_back(e);
          else        exp_q1.push_back(e);
        end
      end else begin
        m_since++;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cycle(input logic en, input logic inc, input logic [1:0] md,
                           input logic [DW-1:0] div);
    enable   = en;
    increase = inc;
    mode     = md;
    step_div = div;
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pos16"},    64'(pos0),    64'd0);
    check({tag, "_out16"},    64'(out0),    64'h1);
    check({tag, "_atend16"},  64'(at_end0), 64'd1);
    check({tag, "_tick16"},   64'(tick0),   64'd0);
    check({tag, "_pos10"},    64'(pos1),    64'd0);
    check({tag, "_out10"},    64'(out1),    64'h1);
    check({tag, "_atend10"},  64'(at_end1), 64'd1);
    check({tag, "_tick10"},   64'(tick1),   64'd0);
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    exp_q0.delete();
    exp_q1.delete();
    model_reset();
    #1 rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst) begin
      if (tick0) begin
        if (exp_q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tick16_unexpected: got tick=1 expected no step (cycle %0d)", cyc);
        end else begin
          e = exp_q0.pop_front();
          check("tick16_cycle", 64'(cyc), 64'(e[103:72]));
          check("pos16", 64'(pos0), 64'(e[71:64]));
          check("out16", 64'(out0), e[63:0] & 64'hFFFF);
          check("atend16", 64'(at_end0), 64'(e[71:64] == 8'd0 || e[71:64] == 8'(W0 - 1)));
        end
      end
      if (tick1) begin
        if (exp_q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tick10_unexpected: got tick=1 expected no step (cycle %0d)", cyc);
        end else begin
          e = exp_q1.pop_front();
          check("tick10_cycle", 64'(cyc), 64'(e[103:72]));
          check("pos10", 64'(pos1), 64'(e[71:64]));
          check("out10", 64'(out1), e[63:0] & 64'h3FF);
          check("atend10", 64'(at_end1), 64'(e[71:64] == 8'd0 || e[71:64] == 8'(W1 - 1)));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       en, inc;
    logic [1:0] md;
    logic [DW-1:0] dv;
    int guard;

    rst      = 1'b1;
    enable   = 1'b0;
    increase = 1'b0;
    mode     = MODE_DOT_WRAP;
    step_div = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    model_reset();

    // dot wrap up, one step per cycle: 1..15,0,1 then on to 13
    repeat (17) run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd0);
    repeat (12) run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd0);

    // bounce entry going up from 13, then run down through 0 and back
    run_cycle(1'b1, 1'b1, MODE_DOT_BOUNCE, 8'd0);
    repeat (4)  run_cycle(1'b1, 1'b0, MODE_DOT_BOUNCE, 8'd0);
    repeat (14) run_cycle(1'b1, 1'b1, MODE_DOT_BOUNCE, 8'd0);

    // bar wrap downward, crossing 0 -> WIDTH-1
    run_cycle(1'b1, 1'b0, MODE_BAR_WRAP, 8'd0);
    repeat (5) run_cycle(1'b1, 1'b0, MODE_BAR_WRAP, 8'd0);

    // prescaler 3, then an enable gap of 5 cycles mid-count
    repeat (12) run_cycle(1'b1, 1'b0, MODE_BAR_WRAP, 8'd3);
    repeat (2)  run_cycle(1'b1, 1'b0, MODE_BAR_WRAP, 8'd3);
    repeat (5)  run_cycle(1'b0, 1'b0, MODE_BAR_WRAP, 8'd3);
    repeat (8)  run_cycle(1'b1, 1'b0, MODE_BAR_WRAP, 8'd3);

    // mode change on the exact cycle a step is due
    guard = 0;
    while (m_since != 3 && guard < 8) begin
      run_cycle(1'b1, 1'b1, MODE_BAR_WRAP, 8'd3);
      guard++;
    end
    run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd3);
    repeat (9) run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd3);

    // divisor shrinks below the running count
    guard = 0;
    while (m_since != 4 && guard < 10) begin
      run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd5);
      guard++;
    end
    repeat (6) run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd1);

    // async reset pulse between edges once the 16-LED lane sits at 9
    guard = 0;
    while (m_pos[0] != 9 && guard < 40) begin
      run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd0);
      guard++;
    end
    async_reset_pulse();
    repeat (5)  run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd0);
    repeat (10) run_cycle(1'b1, 1'b1, MODE_DOT_WRAP, 8'd3);

    // randomised traffic
    md = MODE_DOT_WRAP;
    dv = 8'd3;
    for (int n = 0; n < 600; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      inc = 1'($urandom_range(0, 1));
      if (en && $urandom_range(0, 29) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) dv = 8'($urandom_range(0, 5));
      run_cycle(en, inc, md, dv);
    end

    // drain with scanning frozen
    repeat (8) run_cycle(1'b0, 1'b0, md, dv);
    check("q16_empty", 64'(exp_q0.size()), 64'd0);
    check("q10_empty", 64'(exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
